// File: rtl/min_width_driver.sv
// min_width_driver: output-side pulse shaper for single-bit levels.
// Registers a clean level request and guarantees every high phase lasts at
// least p_min_high cycles and every low phase at least p_min_low cycles.
// Optional feature macro: MIN_WIDTH_DRIVER_PULSE_LATCH_EN. When defined, a
// request pulse that starts and ends inside a hold window is remembered and
// emitted once the window ends, instead of being dropped.
module min_width_driver #(
    parameter int p_min_high = 5,
    parameter int p_min_low  = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_out,
    output logic o_busy
);

    localparam int lp_max = (p_min_high > p_min_low) ? p_min_high : p_min_low;
    localparam int lp_cw  = $clog2(lp_max + 1);
    localparam logic [lp_cw-1:0] lp_high = lp_cw'(p_min_high);
    localparam logic [lp_cw-1:0] lp_low  = lp_cw'(p_min_low);
    localparam logic [lp_cw-1:0] lp_one  = lp_cw'(1);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_LOW       = 3'd1,
        ST_HOLD_LOW  = 3'd2,
        ST_HIGH      = 3'd3,
        ST_HOLD_HIGH = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [lp_cw-1:0] r_count;
    logic [lp_cw-1:0] w_countNext;
    logic             w_expHigh;
    logic             w_expLow;
    logic             w_reqHigh;
    logic             w_reqLow;

    assign w_expHigh = (r_state == ST_HOLD_HIGH) && (r_count == lp_high);
    assign w_expLow  = (r_state == ST_HOLD_LOW) && (r_count == lp_low);

`ifdef MIN_WIDTH_DRIVER_PULSE_LATCH_EN
    logic r_pendHi;
    logic r_pendLo;
    logic w_pendHiNext;
    logic w_pendLoNext;

    // Remember opposite-level requests seen during a hold; every expiry clears both.
    always_comb begin
        w_pendHiNext = r_pendHi;
        w_pendLoNext = r_pendLo;
        if ((r_state == ST_HOLD_LOW) && i_in) begin
            w_pendHiNext = 1'b1;
        end
        if ((r_state == ST_HOLD_HIGH) && !i_in) begin
            w_pendLoNext = 1'b1;
        end
        if (w_expHigh || w_expLow) begin
            w_pendHiNext = 1'b0;
            w_pendLoNext = 1'b0;
        end
    end

    // Pending flag registers, discarded on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pendHi <= 1'b0;
            r_pendLo <= 1'b0;
        end else begin
            r_pendHi <= w_pendHiNext;
            r_pendLo <= w_pendLoNext;
        end
    end

    assign w_reqHigh = i_in | r_pendHi;
    assign w_reqLow  = ~i_in | r_pendLo;
`else
    assign w_reqHigh = i_in;
    assign w_reqLow  = ~i_in;
`endif

    // Next-state and hold counter: each hold runs count 1..p_min, then decides.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        case (r_state)
            ST_START: begin
                w_stateNext = i_in ? ST_HIGH : ST_LOW;
            end
            ST_LOW: begin
                if (i_in) begin
                    w_stateNext = ST_HOLD_HIGH;
                    w_countNext = lp_one;
                end
            end
            ST_HIGH: begin
                if (!i_in) begin
                    w_stateNext = ST_HOLD_LOW;
                    w_countNext = lp_one;
                end
            end
            ST_HOLD_HIGH: begin
                if (w_expHigh) begin
                    if (w_reqLow) begin
                        w_stateNext = ST_HOLD_LOW;
                        w_countNext = lp_one;
                    end else begin
                        w_stateNext = ST_HIGH;
                    end
                end else begin
                    w_countNext = r_count + lp_one;
                end
            end
            ST_HOLD_LOW: begin
                if (w_expLow) begin
                    if (w_reqHigh) begin
                        w_stateNext = ST_HOLD_HIGH;
                        w_countNext = lp_one;
                    end else begin
                        w_stateNext = ST_LOW;
                    end
                end else begin
                    w_countNext = r_count + lp_one;
                end
            end
            default: begin
                w_stateNext = ST_START;
                w_countNext = '0;
            end
        endcase
    end

    // State and counter registers with synchronous reset back to START.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_START;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    assign o_out  = (r_state == ST_HIGH) || (r_state == ST_HOLD_HIGH);
    assign o_busy = (r_state == ST_HOLD_HIGH) || (r_state == ST_HOLD_LOW);

endmodule

// File: tb/tb_min_width_driver.sv
// tb_min_width_driver: directed checks of the minimum-width driver.
// Instance A (high=4, low=3) runs a vector table; instance B (high=6) covers
// reset in mid-hold; instance C (high=low=1) must behave as a plain register.
module tb_min_width_driver;

    typedef struct {
        logic rst;
        logic in;
        logic expOut;
        logic expBusy;
    } vec_t;

    logic clk;
    logic rstA, inA, outA, busyA;
    logic rstB, inB, outB, busyB;
    logic rstC, inC, outC, busyC;

    int   checks;
    int   errors;
    vec_t vecs[$];

    min_width_driver #(.p_min_high(4), .p_min_low(3)) dutA (
        .i_clk(clk), .i_rst(rstA), .i_in(inA), .o_out(outA), .o_busy(busyA)
    );

    min_width_driver #(.p_min_high(6), .p_min_low(5)) dutB (
        .i_clk(clk), .i_rst(rstB), .i_in(inB), .o_out(outB), .o_busy(busyB)
    );

    min_width_driver #(.p_min_high(1), .p_min_low(1)) dutC (
        .i_clk(clk), .i_rst(rstC), .i_in(inC), .o_out(outC), .o_busy(busyC)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic r, input logic i,
                                   input logic o, input logic b);
        vec_t v;
        v.rst     = r;
        v.in      = i;
        v.expOut  = o;
        v.expBusy = b;
        vecs.push_back(v);
    endfunction

    // Drive one instance's inputs, clock once, and settle just after the edge.
    task automatic applyStimulus(input int sel, input logic r, input logic i);
        case (sel)
            0: begin rstA = r; inA = i; end
            1: begin rstB = r; inB = i; end
            default: begin rstC = r; inC = i; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    initial begin
        logic r;
        checks = 0;
        errors = 0;
        rstA = 1'b1; inA = 1'b0;
        rstB = 1'b1; inB = 1'b0;
        rstC = 1'b1; inC = 1'b0;

        // Reset, then START->LOW.
        addVec(1, 0, 0, 0);
        addVec(1, 0, 0, 0);
        addVec(0, 0, 0, 0);
        addVec(0, 0, 0, 0);
        // One-cycle request pulse: stretched to 4 high, then a 3-cycle low hold.
        addVec(0, 1, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 0);
        // Ten-cycle request: 10 high cycles, busy for the first 4 only.
        for (int k = 0; k < 10; k++) begin
            addVec(0, 1, 1, (k < 4) ? 1'b1 : 1'b0);
        end
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 0);
        addVec(0, 0, 0, 0);
        // Get to HIGH again.
        addVec(0, 1, 1, 1);
        addVec(0, 1, 1, 1);
        addVec(0, 1, 1, 1);
        addVec(0, 1, 1, 1);
        addVec(0, 1, 1, 0);
        // Drop, then a short pulse one cycle into the low hold.
        addVec(0, 0, 0, 1);
        addVec(0, 1, 0, 1);
        addVec(0, 0, 0, 1);
`ifdef MIN_WIDTH_DRIVER_PULSE_LATCH_EN
        addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 1, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 1);
        addVec(0, 0, 0, 0);
        addVec(0, 0, 0, 0);
`else
        for (int k = 0; k < 9; k++) begin
            addVec(0, 0, 0, 0);
        end
`endif

        // Apply the table to instance A.
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(0, vecs[k].rst, vecs[k].in);
            checkOutput($sformatf("A.out[%0d]", k), outA, vecs[k].expOut);
            checkOutput($sformatf("A.busy[%0d]", k), busyA, vecs[k].expBusy);
        end

        // Instance B: reset on the second cycle of HOLD_HIGH.
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        checkOutput("B.out.low", outB, 1'b0);
        applyStimulus(1, 0, 1);
        checkOutput("B.out.hold1", outB, 1'b1);
        checkOutput("B.busy.hold1", busyB, 1'b1);
        applyStimulus(1, 0, 1);
        checkOutput("B.out.hold2", outB, 1'b1);
        applyStimulus(1, 1, 0);
        checkOutput("B.out.rst", outB, 1'b0);
        checkOutput("B.busy.rst", busyB, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("B.out.post[%0d]", k), outB, 1'b0);
            checkOutput($sformatf("B.busy.post[%0d]", k), busyB, 1'b0);
        end

        // Instance C: with 1-cycle holds the output is i_in one cycle later.
        applyStimulus(2, 1, 0);
        applyStimulus(2, 1, 0);
        checkOutput("C.out.rst", outC, 1'b0);
        for (int k = 0; k < 100; k++) begin
            r = 1'($urandom_range(0, 1));
            applyStimulus(2, 0, r);
            checkOutput($sformatf("C.out[%0d]", k), outC, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
